// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, branch-predictor counter encoding,
// squash FSM states and the saturating counter update helper.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  bp_ctr_t;

    localparam bp_ctr_t CTR_SNT = 2'd0;
    localparam bp_ctr_t CTR_WNT = 2'd1;
    localparam bp_ctr_t CTR_WT  = 2'd2;
    localparam bp_ctr_t CTR_ST  = 2'd3;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } bp_flush_state_t;

    function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t ctr, input logic taken);
        bp_ctr_t res;
        if (taken) begin
            res = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end else begin
            res = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters: one asynchronous read
// port for fetch, one synchronous saturating-update port for branch resolve.
module bht_2bit
    import lc3b_types::*;
#(
    parameter int      BHT_ENTRIES = 16,
    parameter bp_ctr_t CTR_INIT    = CTR_WNT,
    localparam int     IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output bp_ctr_t          rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [2*BHT_ENTRIES-1:0] ctr_flat;

    // Flops rather than RAM: every counter must return to CTR_INIT on reset.
    genvar gi;
    generate
        for (gi = 0; gi < BHT_ENTRIES; gi++) begin : g_ctr
            bp_ctr_t ctr_q;
            bp_ctr_t ctr_d;

            always_comb begin
                ctr_d = ctr_q;
                if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    ctr_d = bp_ctr_next(ctr_q, wr_taken);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ctr_q <= CTR_INIT;
                end else begin
                    ctr_q <= ctr_d;
                end
            end

            assign ctr_flat[2*gi +: 2] = ctr_q;
        end
    endgenerate

    assign rd_ctr = ctr_flat[{rd_idx, 1'b0} +: 2];

endmodule

// File: rtl/branch_predict_flush_unit.sv
// Branch predictor plus squash controller: predicts at fetch, trains on
// resolve and blanks architectural writes for a window after a redirect.
module branch_predict_flush_unit
    import lc3b_types::*;
#(
    parameter int          BHT_ENTRIES = 16,
    parameter int          FLUSH_DEPTH = 3,
    parameter bp_ctr_t     CTR_INIT    = CTR_WNT,
    parameter logic [15:0] CNT_SAT     = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [15:0] fetch_pc,
    output logic        predict_taken,
    input  logic        resolve_valid,
    input  logic [15:0] resolve_pc,
    input  logic        resolve_taken,
    input  logic        resolve_predicted,
    input  logic        unconditional_branch,
    input  logic        load_regfile_in,
    input  logic        mem_write_in,
    input  logic        branch_enable_in,
    output logic        load_regfile_out,
    output logic        mem_write_out,
    output logic        branch_enable_out,
    output logic        flush,
    output logic        mispredict,
    output logic [15:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    bp_flush_state_t state_q, state_d;
    logic [2:0]      flush_cnt_q, flush_cnt_d;
    logic [15:0]     mis_cnt_q, mis_cnt_d;
    logic            idle;
    logic            trigger;
    logic            train_en;
    bp_ctr_t         rd_ctr;
    logic            unused_pc_bits;

    assign idle       = (state_q == S_IDLE);
    assign mispredict = resolve_valid & (resolve_taken != resolve_predicted) & idle & ~stall;
    assign trigger    = (mispredict | unconditional_branch) & idle & ~stall;
    // Branches resolving inside the window are wrong-path, so they never train.
    assign train_en   = resolve_valid & ~stall & idle;

    bht_2bit #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .CTR_INIT    (CTR_INIT)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (fetch_pc[IDX_W:1]),
        .rd_ctr   (rd_ctr),
        .wr_en    (train_en),
        .wr_idx   (resolve_pc[IDX_W:1]),
        .wr_taken (resolve_taken)
    );

    assign predict_taken  = (rd_ctr >= CTR_WT);
    assign unused_pc_bits = ^{fetch_pc[15:IDX_W+1], fetch_pc[0],
                              resolve_pc[15:IDX_W+1], resolve_pc[0]};

    always_comb begin
        state_d           = state_q;
        flush_cnt_d       = flush_cnt_q;
        flush             = 1'b0;
        load_regfile_out  = load_regfile_in;
        mem_write_out     = mem_write_in;
        branch_enable_out = branch_enable_in;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = 3'(FLUSH_DEPTH);
                end
            end
            S_FLUSH: begin
                flush             = 1'b1;
                load_regfile_out  = 1'b0;
                mem_write_out     = 1'b0;
                branch_enable_out = 1'b0;
                if (!stall) begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                    if (flush_cnt_q == 3'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mis_cnt_d = mis_cnt_q;
        if (mispredict && (mis_cnt_q != CNT_SAT)) begin
            mis_cnt_d = mis_cnt_q + 16'd1;
        end
    end

    assign mispredict_count = mis_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            flush_cnt_q <= 3'd0;
            mis_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            mis_cnt_q   <= mis_cnt_d;
        end
    end

endmodule

// File: doc/branch_predict_flush_unit.md
# branch_predict_flush_unit

Parametrised branch predictor and pipeline squash controller for the LC-3b pipeline. It predicts conditional branches at fetch from a table of 2-bit saturating counters indexed by PC, and trains that table when a branch resolves. On a misprediction or a resolved unconditional branch it squashes the next FLUSH_DEPTH non-stalled cycles of architectural writes: regfile load, memory write and branch enable. It sits between the control/MEM-stage logic and the regfile/data-memory write enables, replacing fixed-depth taken-branch flushing.

## Interface
- BHT_ENTRIES, 16, number of 2-bit counters; power of two, 2..256; IDX_W = $clog2(BHT_ENTRIES)
- FLUSH_DEPTH, 3, squash window length in non-stalled cycles; 1..7
- CTR_INIT, 2'b01, reset value of every counter (weakly not-taken)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  pipeline stall; freezes the FSM, training and the statistics counter
- fetch_pc  in  16  PC of the instruction in fetch (lc3b_word)
- predict_taken  out  1  combinational: counter[fetch_pc[IDX_W:1]] >= 2
- resolve_valid  in  1  a conditional branch is resolving this cycle
- resolve_pc  in  16  PC of the resolving branch
- resolve_taken  in  1  actual outcome
- resolve_predicted  in  1  prediction carried down the pipe with that branch
- unconditional_branch  in  1  JMP/JSR/TRAP resolving this cycle
- load_regfile_in, mem_write_in, branch_enable_in  in  1 each  raw control
- load_regfile_out, mem_write_out, branch_enable_out  out  1 each  gated control
- flush  out  1  high while the squash window is active
- mispredict  out  1  combinational pulse: accepted mispredict trigger this cycle
- mispredict_count  out  16  saturating count of accepted mispredicts

## Operation
- FSM states: S_IDLE and S_FLUSH, plus a flush_cnt register of 3 bits.
- mispredict = resolve_valid & (resolve_taken != resolve_predicted) & state==S_IDLE & !stall.
- trigger = (mispredict | unconditional_branch) & state==S_IDLE & !stall.
- S_IDLE:
  - Gated outputs equal their inputs; flush=0.
  - On trigger: go to S_FLUSH and load flush_cnt = FLUSH_DEPTH.
  - The triggering instruction's own writes pass through.
- S_FLUSH:
  - All three gated outputs are forced to 0; flush=1.
  - If !stall: decrement flush_cnt. When flush_cnt==1 and !stall, return to S_IDLE.
  - If stall: hold state.
  - Triggers are ignored in S_FLUSH because the branches resolving there are squashed.
- Training applies when resolve_valid & !stall & state==S_IDLE:
  - Counter at resolve_pc[IDX_W:1] increments if taken (saturating at 3) and decrements if not taken (saturating at 0).
  - No training in S_FLUSH or while stalled.
- Same-index read and write in one cycle: predict_taken reflects the pre-update value.
- mispredict_count increments by 1 on each cycle mispredict=1 and holds at 16'hFFFF.
  - Unconditional branches do not count.
- Reset (async, rst_n low):
  - state=S_IDLE, flush_cnt=0, all counters=CTR_INIT, mispredict_count=0.
  - flush=0, mispredict=0.
  - Gated outputs pass inputs through.
  - predict_taken reflects CTR_INIT (0 for the default).
- Reset asserted mid-flush aborts the window immediately.

## Timing
- predict_taken and mispredict are same-cycle combinational.
- The squash window starts the cycle after the trigger edge and spans exactly FLUSH_DEPTH non-stalled cycles, plus any stalled cycles inside it.
- A trigger coinciding with stall is not accepted. The source must hold it until stall drops.
- The first cycle back in S_IDLE may accept a new trigger. Back-to-back windows are legal.
- A counter update is visible to predict_taken on the cycle after the training edge.

## Structure
- The shared package (lc3b_types) gains:
  - typedef bp_ctr_t (logic [1:0]).
  - Constants CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3.
  - The FSM enum bp_flush_state_t.
- lc3b_word is reused for the PC ports.
- One sub-module, bht_2bit: the counter array with one async read port and one synchronous saturating-update port, parameterised on BHT_ENTRIES and CTR_INIT.
- The FSM, gating and statistics stay in the top level.

## Test plan
- Reset then fetch_pc=16'h0040 -> predict_taken=0 and all counters=01. With inputs 1/1/1 the gated outputs are 1/1/1 and flush=0.
- Two taken resolves at resolve_pc=16'h0040 with resolve_predicted=0 -> first resolve: mispredict=1 and counter=10. After 3 squash cycles, second resolve (predicted 1): mispredict=0 and counter=11. predict_taken for 16'h0040=1; 16'h0060 (same index, BHT_ENTRIES=16) also=1.
- unconditional_branch=1 for one cycle, FLUSH_DEPTH=3, stall=1 during the 2nd window cycle -> gated outputs 0 for 4 cycles, flush high 4 cycles, mispredict_count unchanged.
- Mispredict trigger with stall=1 -> no state change, no training. Deassert stall -> window starts on the next edge.
- A mispredicting resolve during S_FLUSH -> ignored: no training, count unchanged, window length unchanged.
- Force mispredict_count to 16'hFFFF via 65535 mispredicts (or a short-parameter build) -> stays 16'hFFFF. Assert rst_n=0 mid-flush -> flush=0 immediately and count=0.
